// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one radix-2 step per cycle,
// 33-cycle latency from start to HI/LO update, with MTHI/MTLO write port.
module ex_muldiv_unit (
    input  logic        ck,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        dz
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;
    logic [31:0] mcand;
    logic [32:0] acc;
    logic [31:0] sreg;

    logic        op_signed;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [31:0] addend;
    logic [32:0] mul_sum;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic [32:0] acc_next;
    logic [31:0] sreg_next;
    logic [63:0] product;
    logic [63:0] product_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign op_signed = op[0];
    assign mag1 = (op_signed && data1[31]) ? (32'd0 - data1) : data1;
    assign mag2 = (op_signed && data2[31]) ? (32'd0 - data2) : data2;

    // acc:sreg is shared: {acc, sreg} is the shift-add product register for
    // multiply, and {partial remainder, dividend/quotient} for divide.
    always_comb begin
        addend    = sreg[0] ? mcand : 32'd0;
        mul_sum   = {1'b0, acc[31:0]} + {1'b0, addend};
        shifted   = {acc[31:0], sreg[31]};
        trial     = shifted - {1'b0, mcand};
        acc_next  = acc;
        sreg_next = sreg;
        if (is_div) begin
            if (!trial[32]) begin
                acc_next  = trial;
                sreg_next = {sreg[30:0], 1'b1};
            end else begin
                acc_next  = shifted;
                sreg_next = {sreg[30:0], 1'b0};
            end
        end else begin
            acc_next  = {1'b0, mul_sum[32:1]};
            sreg_next = {mul_sum[0], sreg[31:1]};
        end
    end

    // A zero divisor yields an all-ones quotient and remainder = |dividend|,
    // so the dividend-sign correction restores the raw dividend into HI.
    always_comb begin
        product     = {acc[31:0], sreg};
        product_fix = neg_res ? (64'd0 - product) : product;
        quot_fix    = neg_res ? (32'd0 - sreg) : sreg;
        rem_fix     = neg_rem ? (32'd0 - acc[31:0]) : acc[31:0];
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            sreg     <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            dz       <= 1'b0;
        end else begin
            done <= 1'b0;
            dz   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CALC;
                        cnt      <= '0;
                        is_div   <= op[1];
                        neg_res  <= op_signed && (data1[31] ^ data2[31]);
                        neg_rem  <= op_signed && data1[31];
                        div_zero <= op[1] && (data2 == 32'd0);
                        acc      <= '0;
                        if (op[1]) begin
                            mcand <= mag2;
                            sreg  <= mag1;
                        end else begin
                            mcand <= mag1;
                            sreg  <= mag2;
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    acc  <= acc_next;
                    sreg <= sreg_next;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        lo <= div_zero ? 32'hFFFF_FFFF : quot_fix;
                        hi <= rem_fix;
                    end else begin
                        hi <= product_fix[63:32];
                        lo <= product_fix[31:0];
                    end
                    done  <= 1'b1;
                    dz    <= div_zero;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected HI/LO/dz queued at launch,
// popped and compared when the done pulse appears.
module tb_ex_muldiv_unit;

    logic        ck = 1'b0;
    logic        rst, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] data1, data2, wdata;
    logic [31:0] hi, lo;
    logic        busy, done, dz;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    int   busy_cycles;
    bit   dz_early;
    bit   got_done;

    ex_muldiv_unit dut (
        .ck(ck), .rst(rst), .start(start), .op(op),
        .data1(data1), .data2(data2),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz)
    );

    always #5 ck = ~ck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the start edge,
    // with operands scrambled so the DUT must rely on its captured copies.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; data1 = a; data2 = b;
        @(negedge ck);
        start = 1'b0; op = 2'($urandom); data1 = $urandom; data2 = $urandom;
    endtask

    task automatic wait_done;
        busy_cycles = 0; dz_early = 1'b0; got_done = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            if (dz) dz_early = 1'b1;
            @(negedge ck);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; data1 = '0; data2 = '0; wdata = '0;
        #1;
        total++;
        if ({hi, lo, busy, done, dz} !== 67'd0)
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b, required all 0", hi, lo, busy, done, dz);
        else passed++;
        repeat (2) @(negedge ck);
        rst = 1'b0;
        @(negedge ck);
    endtask

    task automatic test_multu;
        exp_t e;
        exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done;
        total++;
        if (!got_done || busy_cycles != 33)
            $display("FAIL multu_latency: done=%b busy_cycles=%0d, required done and 33", got_done, busy_cycles);
        else passed++;
        e = exp_q.pop_front();
        total++;
        if ({hi, lo, dz} !== e)
            $display("FAIL multu_result: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b", hi, lo, dz, e.hi, e.lo, e.dz);
        else passed++;
        total++;
        if (busy !== 1'b0 || dz_early)
            $display("FAIL multu_done_cycle: busy=%b dz_early=%b, required 0 0", busy, dz_early);
        else passed++;
        @(negedge ck);
        total++;
        if (done !== 1'b0)
            $display("FAIL multu_single_pulse: done=%b, required 0", done);
        else passed++;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        @(negedge ck);
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
        launch(2'b01, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_done;
        e = exp_q.pop_front();
        total++;
        if (!got_done || {hi, lo, dz} !== e)
            $display("FAIL mult_result: done=%b hi=%h lo=%h, required hi=%h lo=%h", got_done, hi, lo, e.hi, e.lo);
        else passed++;
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        launch(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
        total++;
        if (busy !== 1'b1)
            $display("FAIL b2b_accept: busy=%b, required 1", busy);
        else passed++;
        wait_done;
        e = exp_q.pop_front();
        total++;
        if (!got_done || busy_cycles != 33 || {hi, lo, dz} !== e)
            $display("FAIL b2b_div_result: cycles=%0d hi=%h lo=%h dz=%b, required 33 hi=%h lo=%h dz=%b",
                     busy_cycles, hi, lo, dz, e.hi, e.lo, e.dz);
        else passed++;
    endtask

    task automatic test_div;
        exp_t e;
        logic [31:0] va [5]  = '{32'h0000_0064, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0007};
        logic [31:0] vb [5]  = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0010, 32'hFFFF_FFFE};
        logic [1:0]  vo [5]  = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b11};
        logic [64:0] ve [5]  = '{{32'h0000_0064, 32'hFFFF_FFFF, 1'b1},
                                 {32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1},
                                 {32'h0000_0000, 32'h8000_0000, 1'b0},
                                 {32'h0000_000F, 32'h0FFF_FFFF, 1'b0},
                                 {32'h0000_0001, 32'hFFFF_FFFD, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            @(negedge ck);
            exp_q.push_back(ve[i]);
            launch(vo[i], va[i], vb[i]);
            wait_done;
            e = exp_q.pop_front();
            total++;
            if (!got_done || busy_cycles != 33 || dz_early || {hi, lo, dz} !== e)
                $display("FAIL div_case%0d: cycles=%0d dz_early=%b hi=%h lo=%h dz=%b, required 33 0 hi=%h lo=%h dz=%b",
                         i, busy_cycles, dz_early, hi, lo, dz, e.hi, e.lo, e.dz);
            else passed++;
            @(negedge ck);
            total++;
            if (dz !== 1'b0 || done !== 1'b0)
                $display("FAIL div_case%0d_after: dz=%b done=%b, required 0 0", i, dz, done);
            else passed++;
        end
    endtask

    task automatic test_mt;
        exp_t e;
        bit   seen;
        @(negedge ck);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1357_9BDF;
        @(negedge ck);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2468_ACE0;
        @(negedge ck);
        lo_we = 1'b0;
        total++;
        if (hi !== 32'h1357_9BDF || lo !== 32'h2468_ACE0)
            $display("FAIL mt_write: hi=%h lo=%h, required 13579bdf 2468ace0", hi, lo);
        else passed++;
        hi_we = 1'b1; wdata = 32'h1234_5678;
        exp_q.push_back({32'h0000_0000, 32'h0000_0006, 1'b0});
        launch(2'b00, 32'd2, 32'd3);
        hi_we = 1'b0;
        total++;
        if (hi !== 32'h1357_9BDF || busy !== 1'b1)
            $display("FAIL mt_start_conflict: hi=%h busy=%b, required 13579bdf 1", hi, busy);
        else passed++;
        repeat (5) @(negedge ck);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        start = 1'b1; op = 2'b11; data1 = 32'd9; data2 = 32'd0;
        @(negedge ck);
        hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
        @(negedge ck);
        total++;
        if (hi !== 32'h1357_9BDF || lo !== 32'h2468_ACE0)
            $display("FAIL mt_during_busy: hi=%h lo=%h, required 13579bdf 2468ace0", hi, lo);
        else passed++;
        wait_done;
        e = exp_q.pop_front();
        total++;
        if (!got_done || {hi, lo, dz} !== e)
            $display("FAIL start_during_busy: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b", hi, lo, dz, e.hi, e.lo, e.dz);
        else passed++;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge ck);
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen)
            $display("FAIL start_during_busy_extra: extra busy/done=%b, required 0", seen);
        else passed++;
    endtask

    task automatic test_reset_abort;
        exp_t e;
        bit   seen;
        @(negedge ck);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_1111;
        @(negedge ck);
        hi_we = 1'b0; lo_we = 1'b0;
        launch(2'b00, 32'h0000_1234, 32'h0000_5678);
        repeat (10) @(negedge ck);
        rst = 1'b1;
        #1;
        total++;
        if ({hi, lo, busy, done, dz} !== 67'd0)
            $display("FAIL reset_abort: hi=%h lo=%h busy=%b done=%b dz=%b, required all 0", hi, lo, busy, done, dz);
        else passed++;
        #3 rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge ck);
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen)
            $display("FAIL reset_abort_no_done: busy/done seen=%b, required 0", seen);
        else passed++;
        exp_q.push_back({32'h0000_0000, 32'h0000_0019, 1'b0});
        launch(2'b00, 32'd5, 32'd5);
        wait_done;
        e = exp_q.pop_front();
        total++;
        if (!got_done || busy_cycles != 33 || {hi, lo, dz} !== e)
            $display("FAIL post_reset_multu: cycles=%0d hi=%h lo=%h, required 33 hi=%h lo=%h", busy_cycles, hi, lo, e.hi, e.lo);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_multu;
        test_back_to_back;
        test_div;
        test_mt;
        test_reset_abort;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
